period_meter: RTL and testbench

Measures the interval, in `clk` cycles, between consecutive rising edges of a pulse stream, such as the RCO terminal-count pulses of our programmable counters, and returns each result through a valid/ack handshake. It is the receiving end of the counter's RCO output: the counter generates a periodic pulse, and this block recovers the period. It sits beside the counter chain and is read by the control or status logic.

---
 rtl/period_meter_pkg.sv | 12 +
 rtl/edge_detect.sv | 18 +
 rtl/period_meter.sv | 93 +++++++++
 tb/tb_period_meter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared states, default width and saturation helper for period_meter
package period_meter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEAS} pm_state_e;

  localparam int PM_WIDTH = 8;

  function automatic logic [31:0] PM_MAX(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - single-cycle rising-edge detector for a clk-synchronous input
module edge_detect (
  input  logic clk,
  input  logic clr,
  input  logic in,
  output logic rise
);

  logic pulse_d;

  always_ff @(posedge clk) begin
    if (clr) pulse_d <= 1'b0;
    else     pulse_d <= in;
  end

  assign rise = in & ~pulse_d;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures cycles between rising edges of pulse_in, valid/ack result handshake
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH = PM_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ENT,
  input  logic             pulse_in,
  input  logic             ack,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  output logic             OVF,
  output logic             LOST,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(PM_MAX(WIDTH));
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  pm_state_e        state, next_state;
  logic             rise;
  logic             capture;
  logic [WIDTH-1:0] cnt;
  logic             sat;

  edge_detect u_edge (
    .clk  (clk),
    .clr  (clr),
    .in   (pulse_in),
    .rise (rise)
  );

  // Captures only happen while enabled in MEAS; a rise in any other case is ignored.
  assign capture = (state == MEAS) && ENT && rise;
  assign busy    = (state == MEAS);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ENT) next_state = ARM;
      ARM:     if (!ENT) next_state = IDLE;
               else if (rise) next_state = MEAS;
      MEAS:    if (!ENT) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
      Q     <= '0;
      valid <= 1'b0;
      OVF   <= 1'b0;
      LOST  <= 1'b0;
    end else begin
      state <= next_state;

      case (state)
        ARM: begin
          if (ENT && rise) cnt <= CNT_ONE;
        end
        MEAS: begin
          if (!ENT) begin
            cnt <= '0;
            sat <= 1'b0;
          end else if (rise) begin
            cnt <= CNT_ONE;
            sat <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_MAX - CNT_ONE) sat <= 1'b1;
          end
        end
        default: ;
      endcase

      // A new capture wins over ack; only an unacknowledged overwrite is lost.
      if (capture) begin
        Q     <= cnt;
        OVF   <= sat;
        valid <= 1'b1;
        if (valid && !ack) LOST <= 1'b1;
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed table-driven checks for period_meter
module tb_period_meter;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ENT = 1'b0;
  logic       pulse_in = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] Q;
  logic       valid, OVF, LOST, busy;

  int errors = 0;
  int checks = 0;

  period_meter #(.WIDTH(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .ENT      (ENT),
    .pulse_in (pulse_in),
    .ack      (ack),
    .Q        (Q),
    .valid    (valid),
    .OVF      (OVF),
    .LOST     (LOST),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c, e, p, a;
    logic [7:0] q;
    logic       v, o, l, b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c, e, p, a, input logic [7:0] q,
                              input logic v, o, l, b);
    vec_t r;
    r.c = c; r.e = e; r.p = p; r.a = a;
    r.q = q; r.v = v; r.o = o; r.l = l; r.b = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic e, input logic p, input logic a);
    clr = c; ENT = e; pulse_in = p; ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // clr ENT pulse ack | Q valid OVF LOST busy
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));  // reset
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0));  // IDLE->ARM
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,1));  // first edge arms MEAS, no result
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,1,0, 4,1,0,0,1));  // period 4
    tbl.push_back(mk(0,1,0,0, 4,1,0,0,1));
    tbl.push_back(mk(0,1,0,0, 4,1,0,0,1));
    tbl.push_back(mk(0,1,0,0, 4,1,0,0,1));
    tbl.push_back(mk(0,1,1,0, 4,1,0,1,1));  // overwrite without ack -> LOST
    tbl.push_back(mk(0,1,0,0, 4,1,0,1,1));
    tbl.push_back(mk(0,1,0,0, 4,1,0,1,1));
    tbl.push_back(mk(0,1,0,0, 4,1,0,1,1));
    tbl.push_back(mk(0,1,1,1, 4,1,0,1,1));  // ack coincident with capture
    tbl.push_back(mk(0,1,0,0, 4,1,0,1,1));
    tbl.push_back(mk(0,1,0,0, 4,1,0,1,1));  // cnt=3
    tbl.push_back(mk(0,0,1,0, 4,1,0,1,0));  // ENT drop, rise ignored, result kept
    tbl.push_back(mk(0,0,0,1, 4,0,0,1,0));  // ack in IDLE
    tbl.push_back(mk(0,1,1,0, 4,0,0,1,0));  // rise in first ENT cycle missed
    tbl.push_back(mk(0,1,0,0, 4,0,0,1,0));
    tbl.push_back(mk(0,1,1,0, 4,0,0,1,1));  // arming edge, no result
    tbl.push_back(mk(0,1,0,0, 4,0,0,1,1));
    tbl.push_back(mk(0,1,0,0, 4,0,0,1,1));
    tbl.push_back(mk(0,1,1,0, 3,1,0,1,1));  // period 3
    tbl.push_back(mk(0,1,0,0, 3,1,0,1,1));
    tbl.push_back(mk(1,1,1,1, 0,0,0,0,0));  // clr overrides everything
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,1));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].c, tbl[i].e, tbl[i].p, tbl[i].a);
      chk($sformatf("row%0d Q", i),     Q,     tbl[i].q);
      chk($sformatf("row%0d valid", i), valid, tbl[i].v);
      chk($sformatf("row%0d OVF", i),   OVF,   tbl[i].o);
      chk($sformatf("row%0d LOST", i),  LOST,  tbl[i].l);
      chk($sformatf("row%0d busy", i),  busy,  tbl[i].b);
    end

    // pulse_in held high 20 cycles counts as a single edge
    for (int i = 0; i < 19; i++) begin
      cyc(0, 1, 1, 0);
      chk($sformatf("held%0d valid", i), valid, 1'b0);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("held Q", Q, 8'd21);
    chk("held valid", valid, 1'b1);

    // saturation
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("sat Q", Q, 8'd255);
    chk("sat OVF", OVF, 1'b1);
    chk("sat valid", valid, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("after sat Q", Q, 8'd5);
    chk("after sat OVF", OVF, 1'b0);

    // counter source: RCO of a load=9 down counter, ack every result
    begin
      int src = 3;
      int pulses = 0;
      int second_edge = -1;
      int first_valid = -1;
      int results = 0;
      logic prev_v = 1'b0;
      logic p;
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 60; i++) begin
        p = (src == 0);
        src = (src == 0) ? 9 : src - 1;
        if (p) begin
          pulses++;
          if (pulses == 2) second_edge = i;
        end
        cyc(0, 1, p, valid);
        if (valid && !prev_v) begin
          results++;
          if (first_valid < 0) first_valid = i;
          chk($sformatf("rco%0d Q", results), Q, 8'd10);
          chk($sformatf("rco%0d OVF", results), OVF, 1'b0);
          chk($sformatf("rco%0d LOST", results), LOST, 1'b0);
        end
        prev_v = valid;
      end
      chk("rco first latency", first_valid, second_edge);
      chk("rco result count", results, pulses - 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
